// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared types and constants for the serial pattern detector.
// State enum, reset-default pattern/length and the length-width helper.
package seqdet_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [5:0] DEFAULT_PATTERN = 6'b101001;
   localparam int         DEFAULT_LEN     = 6;

   function automatic int len_w(input int pat_max);
      return $clog2(pat_max + 1);
   endfunction

endpackage

// File: rtl/seqdet_match_core.sv
// seqdet_match_core: bit history, fill tracking and length-masked compare.
// Build macro SEQDET_OVERLAP_EN keeps history after a match (overlapping matches).
module seqdet_match_core
   import seqdet_pkg::*;
#(
   parameter int PAT_MAX = 8,
   parameter int LEN_W   = 4
) (
   input  logic               i_clk,
   input  logic               i_resetn,
   input  logic               i_shift,
   input  logic               i_bit,
   input  logic               i_clear,
   input  logic [PAT_MAX-1:0] i_pattern,
   input  logic [LEN_W-1:0]   i_len,
   output logic               o_match
);

`ifdef SEQDET_OVERLAP_EN
   localparam logic OVERLAP = 1'b1;
`else
   localparam logic OVERLAP = 1'b0;
`endif

   logic [PAT_MAX-1:0] hist;
   logic [PAT_MAX-1:0] hist_next;
   logic [PAT_MAX-1:0] mask;
   logic [LEN_W-1:0]   fill;
   logic [LEN_W-1:0]   fill_next;

   // Compare the history including the incoming bit against the pattern
   always_comb begin
      hist_next = {hist[PAT_MAX-2:0], i_bit};
      fill_next = (fill >= LEN_W'(PAT_MAX)) ? fill : fill + LEN_W'(1);
      mask      = '0;
      for (int i = 0; i < PAT_MAX; i++) begin
         mask[i] = (i < int'(i_len));
      end
      o_match = i_shift && (i_len != '0) && (fill_next >= i_len) &&
                ((hist_next & mask) == (i_pattern & mask));
   end

   // History and fill registers; non-overlap mode restarts fill after a hit
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         hist <= '0;
         fill <= '0;
      end else if (i_clear) begin
         hist <= '0;
         fill <= '0;
      end else if (i_shift) begin
         hist <= hist_next;
         fill <= (o_match && !OVERLAP) ? '0 : fill_next;
      end
   end

endmodule

// File: rtl/seqdet_stream_ctrl.sv
// seqdet_stream_ctrl: word stream serializer feeding a pattern detector.
// Optional build macro SEQDET_OVERLAP_EN enables overlapping match counting.
module seqdet_stream_ctrl
   import seqdet_pkg::*;
#(
   parameter  int DATA_W  = 8,
   parameter  int PAT_MAX = 8,
   parameter  int CNT_W   = 8,
   localparam int LEN_W   = len_w(PAT_MAX)
) (
   input  logic               i_clk,
   input  logic               i_resetn,
   input  logic               i_cfg_we,
   input  logic [PAT_MAX-1:0] i_cfg_pattern,
   input  logic [LEN_W-1:0]   i_cfg_len,
   input  logic [CNT_W-1:0]   i_cfg_thresh,
   input  logic               i_word_valid,
   input  logic [DATA_W-1:0]  i_word_data,
   output logic               o_word_ready,
   input  logic               i_clr_cnt,
   output logic               o_busy,
   output logic               o_pattern_found,
   output logic [CNT_W-1:0]   o_match_cnt,
   output logic               o_thresh_hit
);

   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_t             state;
   state_t             state_next;
   logic               run;
   logic [DATA_W-1:0]  word;
   logic [BIT_W-1:0]   bit_cnt;
   logic [PAT_MAX-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic [CNT_W-1:0]   thr_q;
   logic [CNT_W-1:0]   cnt_inc;
   logic               in_idle;
   logic               last_bit;
   logic               accept;
   logic               cfg_load;
   logic               shift;
   logic               match;

   assign in_idle      = (state == IDLE);
   assign last_bit     = (bit_cnt == '0);
   assign o_word_ready = run && ((in_idle && !i_cfg_we) || (!in_idle && last_bit));
   assign accept       = i_word_valid && o_word_ready;
   assign cfg_load     = in_idle && i_cfg_we;
   assign shift        = !in_idle;
   assign o_busy       = shift;
   assign cnt_inc      = (o_match_cnt == '1) ? o_match_cnt : o_match_cnt + CNT_W'(1);

   // State register plus the run flag that holds ready low for one clock
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state <= IDLE;
         run   <= 1'b0;
      end else begin
         state <= state_next;
         run   <= 1'b1;
      end
   end

   // Next state: a word moves us to SHIFT, the last bit returns to IDLE
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept) state_next = SHIFT;
         SHIFT:   if (last_bit && !accept) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Serializer: load on accept, otherwise shift MSB out each SHIFT cycle
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         word    <= '0;
         bit_cnt <= '0;
      end else if (accept) begin
         word    <= i_word_data;
         bit_cnt <= BIT_W'(DATA_W - 1);
      end else if (shift && !last_bit) begin
         word    <= word << 1;
         bit_cnt <= bit_cnt - BIT_W'(1);
      end
   end

   // Runtime configuration, length clamped to the pattern capacity
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         pat_q <= PAT_MAX'(DEFAULT_PATTERN);
         len_q <= LEN_W'(DEFAULT_LEN);
         thr_q <= '0;
      end else if (cfg_load) begin
         pat_q <= i_cfg_pattern;
         len_q <= (i_cfg_len > LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : i_cfg_len;
         thr_q <= i_cfg_thresh;
      end
   end

   seqdet_match_core #(
      .PAT_MAX (PAT_MAX),
      .LEN_W   (LEN_W)
   ) u_core (
      .i_clk     (i_clk),
      .i_resetn  (i_resetn),
      .i_shift   (shift),
      .i_bit     (word[DATA_W-1]),
      .i_clear   (cfg_load),
      .i_pattern (pat_q),
      .i_len     (len_q),
      .o_match   (match)
   );

   // Match pulse, saturating counter and sticky threshold flag
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         o_pattern_found <= 1'b0;
         o_match_cnt     <= '0;
         o_thresh_hit    <= 1'b0;
      end else begin
         o_pattern_found <= match;
         if (i_clr_cnt || cfg_load) begin
            o_match_cnt  <= '0;
            o_thresh_hit <= 1'b0;
         end else if (match) begin
            o_match_cnt <= cnt_inc;
            if (thr_q != '0 && cnt_inc >= thr_q) o_thresh_hit <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seqdet_stream_ctrl.sv
// tb_seqdet_stream_ctrl: scoreboard bench with a bit-queue reference model.
// Honours SEQDET_OVERLAP_EN the same way as the design build.
module tb_seqdet_stream_ctrl;

`ifdef SEQDET_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_we = 1'b0;
   logic [7:0] cfg_pattern = '0;
   logic [3:0] cfg_len = '0;
   logic [7:0] cfg_thresh = '0;
   logic       word_valid = 1'b0;
   logic [7:0] word_data = '0;
   logic       clr_cnt = 1'b0;
   logic       word_ready;
   logic       busy;
   logic       found;
   logic [7:0] match_cnt;
   logic       thresh_hit;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int w_lo = 0;
   int w_hi = 0;
   int busy_acc = 0;

   typedef struct {
      int cyc;
      int cnt;
      bit hit;
   } exp_t;
   exp_t sbq[$];

   bit       m_hist[$];
   int       m_fill;
   int       m_len;
   int       m_cnt;
   int       m_thr;
   bit       m_hit;
   bit [7:0] m_pat;

   seqdet_stream_ctrl #(
      .DATA_W  (8),
      .PAT_MAX (8),
      .CNT_W   (8)
   ) dut (
      .i_clk           (clk),
      .i_resetn        (rst_n),
      .i_cfg_we        (cfg_we),
      .i_cfg_pattern   (cfg_pattern),
      .i_cfg_len       (cfg_len),
      .i_cfg_thresh    (cfg_thresh),
      .i_word_valid    (word_valid),
      .i_word_data     (word_data),
      .o_word_ready    (word_ready),
      .i_clr_cnt       (clr_cnt),
      .o_busy          (busy),
      .o_pattern_found (found),
      .o_match_cnt     (match_cnt),
      .o_thresh_hit    (thresh_hit)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_hist.delete();
      sbq.delete();
      m_fill = 0;
      m_len  = 6;
      m_pat  = 8'b0010_1001;
      m_thr  = 0;
      m_cnt  = 0;
      m_hit  = 1'b0;
   endfunction

   function automatic void model_cfg(bit [7:0] p, int l, int t);
      m_hist.delete();
      m_fill = 0;
      m_pat  = p;
      m_len  = (l > 8) ? 8 : l;
      m_thr  = t;
      m_cnt  = 0;
      m_hit  = 1'b0;
   endfunction

   // Predict every bit of a word accepted at clock edge a.
   function automatic void model_word(bit [7:0] d, int a, int clr_bit);
      for (int k = 1; k <= 8; k++) begin
         bit b;
         bit mt;
         exp_t e;
         b = d[8-k];
         m_hist.push_back(b);
         if (m_hist.size() > 8) void'(m_hist.pop_front());
         m_fill = (m_fill >= 8) ? 8 : m_fill + 1;
         mt = (m_len != 0) && (m_fill >= m_len);
         for (int i = 0; i < m_len; i++) begin
            if (mt && m_hist[m_hist.size()-1-i] != m_pat[i]) mt = 1'b0;
         end
         if (mt && !OVL) m_fill = 0;
         if (clr_bit == k) begin
            m_cnt = 0;
            m_hit = 1'b0;
         end else if (mt) begin
            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
            if (m_thr != 0 && m_cnt >= m_thr) m_hit = 1'b1;
         end
         if (mt) begin
            e.cyc = a + k;
            e.cnt = m_cnt;
            e.hit = m_hit;
            sbq.push_back(e);
         end
      end
   endfunction

   // Monitor: every pulse must match the next scoreboard entry.
   always @(negedge clk) begin
      if (rst_n && found) begin
         chk("pulse_pending", (sbq.size() > 0), 1);
         if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_cnt", match_cnt, e.cnt);
            chk("pulse_hit", thresh_hit, e.hit);
         end
      end
   end

   always @(negedge clk) begin
      if (cyc >= w_lo && cyc < w_hi) busy_acc += int'(busy);
   end

   task automatic send_word(input bit [7:0] d, input bit keep,
                            input int clr_bit, output int acc);
      int t;
      t = 0;
      acc = -1;
      @(negedge clk);
      word_valid = 1'b1;
      word_data  = d;
      forever begin
         #1;
         if (word_ready) begin
            acc = cyc + 1;
            @(posedge clk);
            break;
         end
         @(negedge clk);
         t++;
         if (t > 100) break;
      end
      if (acc < 0) begin
         chk("accept_timeout", t, 0);
         word_valid = 1'b0;
         return;
      end
      model_word(d, acc, clr_bit);
      if (!keep) begin
         @(negedge clk);
         word_valid = 1'b0;
         if (clr_bit > 0) begin
            while (cyc < acc + clr_bit - 1) @(negedge clk);
            clr_cnt = 1'b1;
            @(negedge clk);
            clr_cnt = 1'b0;
         end
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((sbq.size() != 0 || busy) && t < 300) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      chk("drain_queue", sbq.size(), 0);
   endtask

   task automatic cfg_write(input bit [7:0] p, input int l, input int t);
      drain();
      @(negedge clk);
      cfg_we      = 1'b1;
      cfg_pattern = p;
      cfg_len     = 4'(l);
      cfg_thresh  = 8'(t);
      word_valid  = 1'b1;
      word_data   = 8'hFF;
      #1;
      chk("cfg_priority_ready", word_ready, 0);
      @(negedge clk);
      cfg_we     = 1'b0;
      word_valid = 1'b0;
      model_cfg(p, l, t);
   endtask

   task automatic clr_idle();
      drain();
      @(negedge clk);
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      m_cnt = 0;
      m_hit = 1'b0;
   endtask

   initial begin
      int a1;
      int a2;
      int a3;
      bit chain;
      model_reset();
      #1;
      chk("rst_ready", word_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_found", found, 0);
      chk("rst_cnt", match_cnt, 0);
      chk("rst_hit", thresh_hit, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ready_first_clk", word_ready, 0);
      @(negedge clk);
      #1;
      chk("ready_after_run", word_ready, 1);

      send_word(8'hA4, 1'b0, 0, a1);
      drain();
      chk("t1_cnt", match_cnt, 1);

      cfg_write(8'h29, 6, 0);
      send_word(8'hA5, 1'b1, 0, a1);
      send_word(8'h20, 1'b0, 0, a2);
      drain();
      chk("t2_cnt", match_cnt, OVL ? 2 : 1);

      cfg_write(8'h29, 6, 0);
      send_word(8'($urandom), 1'b1, 0, a1);
      w_lo = a1;
      w_hi = a1 + 24;
      busy_acc = 0;
      send_word(8'($urandom), 1'b1, 0, a2);
      send_word(8'($urandom), 1'b0, 0, a3);
      chk("t3_gap12", a2 - a1, 8);
      chk("t3_gap23", a3 - a2, 8);
      drain();
      chk("t3_busy_cycles", busy_acc, 24);
      chk("t3_idle_after", busy, 0);

      cfg_write(8'b0000_0110, 3, 2);
      send_word(8'hDB, 1'b0, 0, a1);
      drain();
      chk("t4_cnt", match_cnt, 2);
      chk("t4_hit", thresh_hit, 1);

      cfg_write(8'h29, 6, 0);
      send_word(8'hA4, 1'b0, 0, a1);
      cfg_we      = 1'b1;
      cfg_pattern = 8'hFF;
      cfg_len     = 4'd1;
      cfg_thresh  = 8'd1;
      @(negedge clk);
      cfg_we = 1'b0;
      drain();
      chk("t5_cfg_in_shift", match_cnt, 1);
      cfg_write(8'h29, 0, 0);
      send_word(8'hA4, 1'b0, 0, a1);
      drain();
      chk("t5_len0_cnt", match_cnt, 0);

      cfg_write(8'h29, 6, 0);
      send_word(8'hA4, 1'b0, 0, a1);
      while (cyc < a1 + 4) @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_found", found, 0);
      chk("t6_cnt", match_cnt, 0);
      chk("t6_ready", word_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_word(8'hA4, 1'b0, 0, a1);
      drain();
      chk("t6_cnt_after", match_cnt, 1);

      cfg_write(8'h29, 6, 1);
      send_word(8'hA4, 1'b0, 6, a1);
      drain();
      chk("clr_coincident_cnt", match_cnt, 0);
      chk("clr_coincident_hit", thresh_hit, 0);

      cfg_write(8'h01, 1, 200);
      for (int i = 0; i < 40; i++) send_word(8'hFF, (i != 39), 0, a1);
      drain();
      chk("sat_cnt", match_cnt, 255);
      chk("sat_hit", thresh_hit, 1);

      cfg_write(8'($urandom), 12, 3);
      chain = 1'b0;
      for (int i = 0; i < 200; i++) begin
         int r;
         bit keep;
         int cb;
         r = int'($urandom_range(0, 11));
         if (!chain && r == 0) begin
            cfg_write(8'($urandom), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 5)));
         end else if (!chain && r == 1) begin
            clr_idle();
         end else begin
            keep  = ($urandom_range(0, 2) == 0);
            cb    = (!keep && $urandom_range(0, 4) == 0) ?
                    int'($urandom_range(1, 7)) : 0;
            send_word(8'($urandom), keep, cb, a1);
            chain = keep;
            if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end
      if (chain) send_word(8'($urandom), 1'b0, 0, a1);
      drain();
      chk("rand_cnt", match_cnt, m_cnt);
      chk("rand_hit", thresh_hit, m_hit);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
